// File: rtl/ce_pkg.sv
// Shared encodings for the CE DCT->IDCT window stage.
// Mode values as carried on mode_in, frame-tracker states and error bit positions.
// No logic; imported by the window top and its gain helper.
package ce_pkg;

    typedef enum logic [1:0] {
        CE_WIN_BYPASS   = 2'b00,
        CE_WIN_RECT     = 2'b01,
        CE_WIN_TAPER    = 2'b10,
        CE_WIN_RECT_ALT = 2'b11
    } ce_win_mode_e;

    typedef enum logic {
        CE_IDLE  = 1'b0,
        CE_FRAME = 1'b1
    } ce_state_e;

    // source_error bit positions
    localparam int CE_ERR_LEN = 0;  // frame length mismatch / sop inside a frame
    localparam int CE_ERR_OOF = 1;  // beat accepted outside any frame

endpackage

// File: rtl/ce_win_gain.sv
// Per-bin forward/reverse window gain from (index, frame length, clamped window length, mode).
// Latency: purely combinational.
// Backpressure: none; evaluated on whatever beat is presented.
module ce_win_gain
    import ce_pkg::*;
#(
    parameter int W_PTS      = 12,
    parameter int TAPER_LOG2 = 3,
    parameter int GW         = TAPER_LOG2 + 1
) (
    input  logic [W_PTS-1:0] k_i,
    input  logic [W_PTS-1:0] n_i,
    input  logic [W_PTS-1:0] le_i,
    input  logic [1:0]       mode_i,
    output logic [GW-1:0]    gf_o,
    output logic [GW-1:0]    gr_o
);

    localparam logic [W_PTS:0]  T_W = (W_PTS + 1)'(2 ** TAPER_LOG2);
    localparam logic [GW-1:0]   T_G = GW'(2 ** TAPER_LOG2);

    logic [W_PTS-1:0] rev_start;
    logic [W_PTS:0]   fwd_dist;
    logic [W_PTS:0]   rev_dist;

    // Distances to the window edges; le_i <= n_i so rev_start never underflows.
    always_comb begin
        rev_start = n_i - le_i;
        fwd_dist  = {1'b0, le_i} - {1'b0, k_i};
        rev_dist  = {1'b0, k_i} - {1'b0, rev_start} + (W_PTS + 1)'(1);
    end

    // Gain select: bypass = unity, rect = unity inside window, taper ramps over T bins at the edge.
    always_comb begin
        gf_o = '0;
        gr_o = '0;
        if (mode_i == CE_WIN_BYPASS) begin
            gf_o = T_G;
            gr_o = T_G;
        end else begin
            if (k_i < le_i) begin
                gf_o = (mode_i == CE_WIN_TAPER && fwd_dist < T_W) ? fwd_dist[GW-1:0] : T_G;
            end
            if (k_i >= rev_start) begin
                gr_o = (mode_i == CE_WIN_TAPER && rev_dist < T_W) ? rev_dist[GW-1:0] : T_G;
            end
        end
    end

endmodule

// File: rtl/ce_window_taper.sv
// Windows forward/reversed DCT bins with run-time length and bypass/rect/taper mode.
// Latency: 2 accepted beats (S1 index+gain, S2 multiply+round).
// Backpressure: whole pipe advances on !source_valid | source_ready; sink_ready mirrors it.
module ce_window_taper
    import ce_pkg::*;
#(
    parameter int W_DATA     = 24,
    parameter int W_PTS      = 12,
    parameter int TAPER_LOG2 = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              sink_valid,
    output logic              sink_ready,
    input  logic [1:0]        sink_error,
    input  logic              sink_sop,
    input  logic              sink_eop,
    input  logic [W_DATA-1:0] sink_real,
    input  logic [W_DATA-1:0] sink_imag,
    input  logic [W_DATA-1:0] sink_real_rev,
    input  logic [W_DATA-1:0] sink_imag_rev,
    input  logic [W_PTS-1:0]  fftpts_in,
    input  logic [W_PTS-1:0]  win_len_in,
    input  logic [1:0]        mode_in,
    output logic              source_valid,
    input  logic              source_ready,
    output logic [1:0]        source_error,
    output logic              source_sop,
    output logic              source_eop,
    output logic [W_DATA-1:0] source_real,
    output logic [W_DATA-1:0] source_imag,
    output logic [W_DATA-1:0] source_real_rev,
    output logic [W_DATA-1:0] source_imag_rev,
    output logic [W_PTS-1:0]  fftpts_out
);

    localparam int GW = TAPER_LOG2 + 1;
    localparam int PW = W_DATA + TAPER_LOG2 + 1;
    localparam logic signed [PW-1:0] RND = PW'(2 ** (TAPER_LOG2 - 1));

    // Signed x*g with round-half-up; g <= T keeps the result inside W_DATA.
    function automatic logic [W_DATA-1:0] apply_gain(input logic [W_DATA-1:0] x,
                                                     input logic [GW-1:0]     g);
        logic signed [PW-1:0] p;
        p = $signed({{(PW - W_DATA){x[W_DATA-1]}}, x}) * $signed({{(PW - GW){1'b0}}, g});
        p = p + RND;
        return W_DATA'(p >>> TAPER_LOG2);
    endfunction

    logic en;
    logic acc;

    ce_state_e        state_q, state_d;
    logic [W_PTS-1:0] k_q, k_d;
    logic [W_PTS-1:0] n_q, n_d;
    logic [W_PTS-1:0] l_q, l_d;
    logic [1:0]       mode_q, mode_d;

    logic [W_PTS-1:0] k_cur, n_cur, l_cur, le_cur, last_idx;
    logic [1:0]       mode_cur;
    logic             in_frame;
    logic [1:0]       err_cur;
    logic [GW-1:0]    gf, gr;

    logic              s1_vld_q, s1_sop_q, s1_eop_q;
    logic [1:0]        s1_err_q;
    logic [W_PTS-1:0]  s1_n_q;
    logic [GW-1:0]     s1_gf_q, s1_gr_q;
    logic [W_DATA-1:0] s1_re_q, s1_im_q, s1_rre_q, s1_rim_q;

    logic              src_vld_q, src_sop_q, src_eop_q;
    logic [1:0]        src_err_q;
    logic [W_PTS-1:0]  src_n_q;
    logic [W_DATA-1:0] src_re_q, src_im_q, src_rre_q, src_rim_q;

    assign en         = !src_vld_q || source_ready;
    assign acc        = sink_valid && en;
    assign sink_ready = en;
    assign le_cur     = (l_cur < n_cur) ? l_cur : n_cur;

    // Per-beat frame context: sop beats use the live config, others the latched one.
    always_comb begin
        state_d  = state_q;
        k_d      = k_q;
        n_d      = n_q;
        l_d      = l_q;
        mode_d   = mode_q;
        k_cur    = k_q;
        n_cur    = n_q;
        l_cur    = l_q;
        mode_cur = mode_q;
        in_frame = 1'b0;
        err_cur  = sink_error;
        if (sink_sop) begin
            k_cur    = '0;
            n_cur    = fftpts_in;
            l_cur    = win_len_in;
            mode_cur = mode_in;
            in_frame = 1'b1;
            if (state_q == CE_FRAME) begin
                err_cur[CE_ERR_LEN] = 1'b1;
            end
        end else if (state_q == CE_FRAME) begin
            in_frame = 1'b1;
        end else begin
            err_cur[CE_ERR_OOF] = 1'b1;
        end
        last_idx = n_cur - W_PTS'(1);
        if (in_frame && (sink_eop ? (k_cur != last_idx) : (k_cur >= last_idx))) begin
            err_cur[CE_ERR_LEN] = 1'b1;
        end
        if (acc && in_frame) begin
            state_d = sink_eop ? CE_IDLE : CE_FRAME;
            k_d     = (k_cur == '1) ? k_cur : k_cur + W_PTS'(1);
            n_d     = n_cur;
            l_d     = l_cur;
            mode_d  = mode_cur;
        end
    end

    ce_win_gain #(
        .W_PTS      (W_PTS),
        .TAPER_LOG2 (TAPER_LOG2),
        .GW         (GW)
    ) u_gain (
        .k_i    (k_cur),
        .n_i    (n_cur),
        .le_i   (le_cur),
        .mode_i (mode_cur),
        .gf_o   (gf),
        .gr_o   (gr)
    );

    // Frame tracker FSM: index, latched config and IDLE/FRAME state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= CE_IDLE;
            k_q     <= '0;
            n_q     <= '0;
            l_q     <= '0;
            mode_q  <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            n_q     <= n_d;
            l_q     <= l_d;
            mode_q  <= mode_d;
        end
    end

    // S1: capture samples with their gains; out-of-frame beats get zero gain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_vld_q <= 1'b0;
            s1_sop_q <= 1'b0;
            s1_eop_q <= 1'b0;
            s1_err_q <= '0;
            s1_n_q   <= '0;
            s1_gf_q  <= '0;
            s1_gr_q  <= '0;
            s1_re_q  <= '0;
            s1_im_q  <= '0;
            s1_rre_q <= '0;
            s1_rim_q <= '0;
        end else if (en) begin
            s1_vld_q <= sink_valid;
            if (sink_valid) begin
                s1_sop_q <= sink_sop;
                s1_eop_q <= sink_eop;
                s1_err_q <= err_cur;
                s1_n_q   <= n_cur;
                s1_gf_q  <= in_frame ? gf : '0;
                s1_gr_q  <= in_frame ? gr : '0;
                s1_re_q  <= sink_real;
                s1_im_q  <= sink_imag;
                s1_rre_q <= sink_real_rev;
                s1_rim_q <= sink_imag_rev;
            end
        end
    end

    // S2: scale by gain and round into the output register; holds while stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            src_vld_q <= 1'b0;
            src_sop_q <= 1'b0;
            src_eop_q <= 1'b0;
            src_err_q <= '0;
            src_n_q   <= '0;
            src_re_q  <= '0;
            src_im_q  <= '0;
            src_rre_q <= '0;
            src_rim_q <= '0;
        end else if (en) begin
            src_vld_q <= s1_vld_q;
            if (s1_vld_q) begin
                src_sop_q <= s1_sop_q;
                src_eop_q <= s1_eop_q;
                src_err_q <= s1_err_q;
                src_n_q   <= s1_n_q;
                src_re_q  <= apply_gain(s1_re_q, s1_gf_q);
                src_im_q  <= apply_gain(s1_im_q, s1_gf_q);
                src_rre_q <= apply_gain(s1_rre_q, s1_gr_q);
                src_rim_q <= apply_gain(s1_rim_q, s1_gr_q);
            end
        end
    end

    assign source_valid    = src_vld_q;
    assign source_sop      = src_sop_q;
    assign source_eop      = src_eop_q;
    assign source_error    = src_err_q;
    assign fftpts_out      = src_n_q;
    assign source_real     = src_re_q;
    assign source_imag     = src_im_q;
    assign source_real_rev = src_rre_q;
    assign source_imag_rev = src_rim_q;

endmodule
